// File: rtl/flopr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : flopr_pkg
//  Description : Shared constants for the flopr register primitive and the
//                2-bit external-memory handshake state kept in a flopr #(2).
//  Revision    : 1.0 - initial release
// ============================================================================
package flopr_pkg;

    localparam int unsigned FLOPR_DEFAULT_WIDTH = 8;
    localparam int unsigned FLOPR_MAX_WIDTH     = 1024;

    // Memory-model handshake states, held in a 2-bit flopr.
    localparam logic [1:0] MEM_IDLE = 2'b00;
    localparam logic [1:0] MEM_REQ  = 2'b01;
    localparam logic [1:0] MEM_ACK  = 2'b10;

    // Next state of the handshake loop: IDLE -> REQ -> ACK -> IDLE while en.
    function automatic logic [1:0] mem_next_state(input logic [1:0] state,
                                                  input logic       en);
        logic [1:0] nxt;
        nxt = state;
        if (en) begin
            case (state)
                MEM_IDLE: nxt = MEM_REQ;
                MEM_REQ:  nxt = MEM_ACK;
                default:  nxt = MEM_IDLE;
            endcase
        end
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/flopr_if.sv
`default_nettype none
// ============================================================================
//  Module      : flopr_if
//  Description : Data bundle around a flopr instance: the producer drives the
//                next-state value, the register returns the held state.
//  Revision    : 1.0 - initial release
// ============================================================================
interface flopr_if
    import flopr_pkg::*;
#(
    parameter int WIDTH = FLOPR_DEFAULT_WIDTH
);

    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;

    // Producer of next-state data; observes the registered state.
    modport master (output d, input q);
    // The register itself.
    modport slave  (input d, output q);

endinterface
`default_nettype wire

// File: rtl/flopr.sv
`default_nettype none
// ============================================================================
//  Module      : flopr
//  Description : WIDTH-bit D register with synchronous active-high reset to
//                RESETVAL. Nothing but the capture/reset mux and the flops.
//  Revision    : 1.0 - initial release
// ============================================================================
module flopr
    import flopr_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] RESETVAL = {WIDTH{1'b0}}
) (
    input  wire logic             ph1,
    input  wire logic             reset,
    input  wire logic [WIDTH-1:0] d,
    output logic      [WIDTH-1:0] q
);

    logic [WIDTH-1:0] state_d;
    logic [WIDTH-1:0] state_q;

    // Reject out-of-range widths at elaboration time.
    if ((WIDTH < 1) || (WIDTH > int'(FLOPR_MAX_WIDTH))) begin : g_bad_width
        $error("flopr: WIDTH out of range");
    end

    // Next state is the input data; reset is applied in the clocked process.
    assign state_d = d;

    // Capture on the rising edge; reset wins. The ternary keeps an X on reset
    // visible on q instead of silently selecting the data leg.
    always_ff @(posedge ph1) begin
        state_q <= reset ? RESETVAL : state_d;
    end

    assign q = state_q;

endmodule
`default_nettype wire

// File: tb/tb_flopr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_flopr
//  Description : Directed self-checking bench for flopr: reset, capture,
//                hold, synchronous reset, custom reset value, FSM loop.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_flopr;
    import flopr_pkg::*;

    logic ph1;
    logic rst2;
    logic rst32;
    logic rstf;
    logic fsm_en;

    int n_cmp;
    int n_bad;

    flopr_if #(.WIDTH(2))  bus2  ();
    flopr_if #(.WIDTH(32)) bus32 ();
    flopr_if #(.WIDTH(2))  busf  ();

    flopr #(.WIDTH(2)) u_dut2 (
        .ph1   (ph1),
        .reset (rst2),
        .d     (bus2.d),
        .q     (bus2.q)
    );

    flopr #(.WIDTH(32), .RESETVAL(32'hBFC0_0000)) u_dut32 (
        .ph1   (ph1),
        .reset (rst32),
        .d     (bus32.d),
        .q     (bus32.q)
    );

    flopr #(.WIDTH(2)) u_fsm (
        .ph1   (ph1),
        .reset (rstf),
        .d     (busf.d),
        .q     (busf.q)
    );

    // Next-state logic wrapped around the FSM register.
    always_comb begin
        busf.d = mem_next_state(busf.q, fsm_en);
    end

    initial ph1 = 1'b0;
    always #5 ph1 = ~ph1;

    task automatic tick();
        @(posedge ph1);
        #1;
    endtask

    task automatic test_reset();
        rst2   = 1'b1;
        bus2.d = 2'b11;
        tick();
        n_cmp++;
        if (bus2.q !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_edge1: got %b want 00", bus2.q);
        end
        tick();
        n_cmp++;
        if (bus2.q !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_edge2: got %b want 00", bus2.q);
        end
    endtask

    task automatic test_capture();
        logic [1:0] vec [3];
        vec[0] = 2'b01;
        vec[1] = 2'b10;
        vec[2] = 2'b00;
        rst2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus2.d = vec[i];
            tick();
            n_cmp++;
            if (bus2.q !== vec[i]) begin
                n_bad++;
                $display("FAIL capture_%0d: got %b want %b", i, bus2.q, vec[i]);
            end
        end
    endtask

    task automatic test_hold();
        // q is 00 from the capture test.
        #2 bus2.d = 2'b11;
        #1;
        n_cmp++;
        if (bus2.q !== 2'b00) begin
            n_bad++;
            $display("FAIL hold_mid_11: got %b want 00", bus2.q);
        end
        bus2.d = 2'b01;
        #1;
        n_cmp++;
        if (bus2.q !== 2'b00) begin
            n_bad++;
            $display("FAIL hold_mid_01: got %b want 00", bus2.q);
        end
        tick();
        n_cmp++;
        if (bus2.q !== 2'b01) begin
            n_bad++;
            $display("FAIL hold_capture: got %b want 01", bus2.q);
        end
    endtask

    task automatic test_sync_reset();
        bus2.d = 2'b10;
        tick();
        n_cmp++;
        if (bus2.q !== 2'b10) begin
            n_bad++;
            $display("FAIL sreset_setup: got %b want 10", bus2.q);
        end
        // Glitch reset between edges; no edge sees it.
        #2 rst2 = 1'b1;
        #1;
        n_cmp++;
        if (bus2.q !== 2'b10) begin
            n_bad++;
            $display("FAIL sreset_glitch_high: got %b want 10", bus2.q);
        end
        rst2 = 1'b0;
        tick();
        n_cmp++;
        if (bus2.q !== 2'b10) begin
            n_bad++;
            $display("FAIL sreset_glitch_edge: got %b want 10", bus2.q);
        end
        // Reset held across an edge overrides pending data.
        rst2   = 1'b1;
        bus2.d = 2'b01;
        tick();
        n_cmp++;
        if (bus2.q !== 2'b00) begin
            n_bad++;
            $display("FAIL sreset_edge: got %b want 00", bus2.q);
        end
        rst2 = 1'b0;
        tick();
        n_cmp++;
        if (bus2.q !== 2'b01) begin
            n_bad++;
            $display("FAIL sreset_resume: got %b want 01", bus2.q);
        end
    endtask

    task automatic test_custom_reset();
        rst32   = 1'b1;
        bus32.d = 32'h1234_5678;
        tick();
        n_cmp++;
        if (bus32.q !== 32'hBFC0_0000) begin
            n_bad++;
            $display("FAIL custom_reset: got %h want bfc00000", bus32.q);
        end
        rst32 = 1'b0;
        tick();
        n_cmp++;
        if (bus32.q !== 32'h1234_5678) begin
            n_bad++;
            $display("FAIL custom_capture: got %h want 12345678", bus32.q);
        end
        bus32.d = 32'hA5A5_0F0F;
        tick();
        n_cmp++;
        if (bus32.q !== 32'hA5A5_0F0F) begin
            n_bad++;
            $display("FAIL custom_capture2: got %h want a5a50f0f", bus32.q);
        end
    endtask

    task automatic test_fsm_loop();
        logic [1:0] exp_seq [5];
        exp_seq[0] = 2'b01;
        exp_seq[1] = 2'b10;
        exp_seq[2] = 2'b00;
        exp_seq[3] = 2'b01;
        exp_seq[4] = 2'b10;
        fsm_en = 1'b1;
        rstf   = 1'b1;
        tick();
        n_cmp++;
        if (busf.q !== 2'b00) begin
            n_bad++;
            $display("FAIL fsm_reset: got %b want 00", busf.q);
        end
        rstf = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (busf.q !== exp_seq[i]) begin
                n_bad++;
                $display("FAIL fsm_step_%0d: got %b want %b", i, busf.q, exp_seq[i]);
            end
        end
        // With en low the loop parks in its current state.
        fsm_en = 1'b0;
        tick();
        n_cmp++;
        if (busf.q !== 2'b10) begin
            n_bad++;
            $display("FAIL fsm_park: got %b want 10", busf.q);
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst2    = 1'b1;
        rst32   = 1'b1;
        rstf    = 1'b1;
        fsm_en  = 1'b0;
        bus2.d  = 2'b00;
        bus32.d = 32'h0;
        #1;
        test_reset();
        test_capture();
        test_hold();
        test_sync_reset();
        test_custom_reset();
        test_fsm_loop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
